// File: rtl/mult_pipe_top.sv
// mult_pipe_top: W x W signed/unsigned multiplier behind a STAGES-deep valid/ready pipeline.
// Define APPROX_EN for a truncated-magnitude product (low TRUNC bits of each |operand| zeroed).
module mult_pipe_top #(
  parameter int W = 16,
  parameter int STAGES = 3,
  parameter int TRUNC = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  x,
  input  logic [W-1:0]                  y,
  input  logic                          in_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*W-1:0]                p_out,
  output logic [$clog2(STAGES+1)-1:0]   inflight
);
  localparam int CW = $clog2(STAGES+1);
  if (W < 2 || STAGES < 1 || TRUNC < 0 || TRUNC >= W) begin : g_bad_params
    $error("mult_pipe_top: illegal parameters");
  end
  logic [STAGES-1:0] v, fr;
  logic [2*W-1:0] d [STAGES];
  logic [2*W-1:0] prod;
  logic acc, pop;
`ifdef APPROX_EN
  logic sx, sy;
  logic [W-1:0] mx, my;
  logic [2*W-1:0] mp;
  always_comb begin
    sx = in_signed & x[W-1];
    sy = in_signed & y[W-1];
    mx = (sx ? -x : x) & ({W{1'b1}} << TRUNC);
    my = (sy ? -y : y) & ({W{1'b1}} << TRUNC);
    mp = {{W{1'b0}}, mx} * {{W{1'b0}}, my};
    prod = (sx ^ sy) ? -mp : mp;
  end
`else
  logic [2*W-1:0] xe, ye;
  always_comb begin
    xe = {{W{in_signed & x[W-1]}}, x};
    ye = {{W{in_signed & y[W-1]}}, y};
    prod = xe * ye;
  end
`endif
  // a stage can load iff some stage at or after it is empty, or the output drains
  for (genvar k = 0; k < STAGES; k++) begin : g_fr
    assign fr[k] = out_ready | ~&v[STAGES-1:k];
  end
  assign in_ready = !rst & fr[0];
  assign acc = in_valid & in_ready;
  assign pop = v[STAGES-1] & out_ready;
  assign out_valid = v[STAGES-1];
  assign p_out = d[STAGES-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      inflight <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      inflight <= inflight + CW'(acc) - CW'(pop);
      if (fr[0]) v[0] <= in_valid;
      if (acc) d[0] <= prod;
      for (int i = 1; i < STAGES; i++) begin
        if (fr[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_pipe_top.sv
// tb_mult_pipe_top: directed and randomized checks of mult_pipe_top against a queue-based reference model.
module tb_mult_pipe_top;
  localparam int STAGES = 3;
  localparam int TRUNC = 5;
  logic clk = 0, rst = 1, in_valid = 0, in_signed = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] x = 0, y = 0;
  logic [31:0] p_out;
  logic [1:0] inflight;
  int checks = 0, failures = 0;
  int cnt = 0;
  logic [31:0] q[$];
  logic hold_v = 0;
  logic [31:0] hold_p;
  logic pres = 0;
  typedef struct {logic [15:0] a; logic [15:0] b; logic s;} txn_t;
  txn_t src[$];

  mult_pipe_top dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out), .inflight(inflight));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint va = s ? longint'($signed(a)) : longint'(a);
    longint vb = s ? longint'($signed(b)) : longint'(b);
    longint p = va * vb;
`ifdef APPROX_EN
    longint ma = va < 0 ? -va : va;
    longint mb = vb < 0 ? -vb : vb;
    ma = (ma >> TRUNC) << TRUNC;
    mb = (mb >> TRUNC) << TRUNC;
    p = ((va < 0) != (vb < 0)) ? -(ma * mb) : ma * mb;
`endif
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, check pre-edge handshake, advance model, check post-edge state
  task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic ordy, input logic r, output logic acc);
    logic pop;
    in_valid = iv; x = a; y = b; in_signed = s; out_ready = ordy; rst = r;
    #1;
    chk("in_ready", in_ready, !r && (ordy || cnt < STAGES));
    acc = iv && in_ready && !r;
    pop = !r && out_valid && ordy;
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", p_out, hold_p);
    end
    if (pop) begin
      if (q.size() > 0) chk("product", p_out, q.pop_front());
      else chk("pop_empty", out_valid, 0);
    end
    hold_v = !r && out_valid && !ordy;
    hold_p = p_out;
    @(posedge clk);
    if (r) begin
      q.delete();
      cnt = 0;
    end else begin
      if (acc) q.push_back(ref_prod(a, b, s));
      cnt = cnt + int'(acc) - int'(pop);
    end
    #1;
    chk("inflight", inflight, cnt);
    if (r) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_p_out", p_out, 0);
    end
  endtask

  // mode 0: out_ready=0, 1: out_ready=1, 2: random out_ready
  task automatic run(input int n, input int mode);
    logic iv, ordy, acc;
    txn_t t;
    for (int i = 0; i < n; i++) begin
      iv = src.size() > 0 && (pres || $urandom_range(3) != 0);
      t = src.size() > 0 ? src[0] : '{16'($urandom), 16'($urandom), 1'($urandom)};
      ordy = mode == 2 ? ($urandom_range(9) < 7) : (mode == 1);
      if (mode != 2) iv = src.size() > 0;
      cyc(iv, t.a, t.b, t.s, ordy, 0, acc);
      pres = iv && !acc;
      if (acc) void'(src.pop_front());
    end
  endtask

  initial begin
    logic acc;
    cyc(1, 16'h1234, 16'h5678, 0, 1, 1, acc);
    cyc(1, 16'h1234, 16'h5678, 0, 1, 1, acc);
    chk("reset_inflight", inflight, 0);
`ifndef APPROX_EN
    // latency: accepting cycle is cycle 0, out_valid appears in cycle STAGES
    src.push_back('{16'd3, 16'd4, 1'b0});
    run(1, 1);
    chk("lat_c1", out_valid, 0);
    run(1, 1);
    chk("lat_c2", out_valid, 0);
    run(1, 1);
    chk("lat_c3", out_valid, 1);
    chk("u_3x4", p_out, 32'h0000000C);
    run(3, 1);
    chk("lat_drained", inflight, 0);
    src.push_back('{16'hFFFF, 16'd2, 1'b1});
    src.push_back('{16'hFFFF, 16'd2, 1'b0});
    run(3, 1);
    chk("s_ffff_x2", p_out, 32'hFFFFFFFE);
    run(1, 1);
    chk("b2b_valid", out_valid, 1);
    chk("u_ffff_x2", p_out, 32'h0001FFFE);
    run(3, 1);
    src.push_back('{16'h8000, 16'h8000, 1'b1});
    src.push_back('{16'h8000, 16'h7FFF, 1'b1});
    run(3, 1);
    chk("s_min_sq", p_out, 32'h40000000);
    run(1, 1);
    chk("s_min_max", p_out, 32'hC0008000);
    run(3, 1);
`else
    src.push_back('{16'h0123, 16'h0045, 1'b0});
    src.push_back('{16'hFEDD, 16'h0045, 1'b1});
    run(3, 1);
    chk("apx_u", p_out, 32'h00004800);
    run(1, 1);
    chk("apx_s", p_out, 32'hFFFFB800);
    run(3, 1);
`endif
    // backpressure: five products 1..5, only STAGES fit
    for (int k = 1; k <= 5; k++) src.push_back('{16'(k), 16'd1, 1'b0});
    run(6, 0);
    chk("bp_inflight", inflight, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", p_out, 1);
    for (int k = 1; k <= 5; k++) begin
      chk("bp_nogap", out_valid, 1);
      chk("bp_order", p_out, k);
      run(1, 1);
    end
    run(3, 1);
    chk("bp_drained", inflight, 0);
    // reset with two transactions in flight
    src.push_back('{16'h0101, 16'h0202, 1'b0});
    src.push_back('{16'h0303, 16'h0404, 1'b1});
    run(2, 1);
    cyc(0, 0, 0, 0, 1, 1, acc);
    run(6, 1);
    chk("no_stale", out_valid, 0);
    // randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) src.push_back('{16'($urandom), 16'($urandom), 1'($urandom)});
    run(500, 2);
    run(320, 1);
    chk("rand_drained", inflight, 0);
    chk("rand_all_sent", src.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
